// File: rtl/uop_pkg.sv
// uop_pkg: shared widths and uop word layout for the microcode-to-issue path
package uop_pkg;
  localparam int MAX_PREDICT_DEPTH_BITS = 2;
  localparam int INSN_WIDTH = 32;
  localparam int UOP_BUF_SIZE = 8;
  localparam int UOP_BUF_WIDTH = 2*MAX_PREDICT_DEPTH_BITS + 2*INSN_WIDTH;
  typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] branch_tag_t;
  typedef struct packed {
    branch_tag_t tag_a;
    branch_tag_t tag_b;
    logic [INSN_WIDTH-1:0] insn_a;
    logic [INSN_WIDTH-1:0] insn_b;
  } uop_word_t;
endpackage

// File: rtl/uop_slot_select.sv
// uop_slot_select: picks the oldest valid slot of a uop word and decides whether the word retires
module uop_slot_select import uop_pkg::*; #(
  parameter int TAG_BITS = MAX_PREDICT_DEPTH_BITS,
  parameter int INSN_WIDTH = uop_pkg::INSN_WIDTH
) (
  input  logic v_a,
  input  logic v_b,
  input  logic [2*TAG_BITS+2*INSN_WIDTH-1:0] uop,
  input  logic issue,
  output logic offer,
  output logic [INSN_WIDTH-1:0] insn,
  output logic [TAG_BITS-1:0] tag,
  output logic slot,
  output logic pop
);
  localparam int W = 2*TAG_BITS + 2*INSN_WIDTH;
  assign offer = v_a || v_b;
  assign slot = !v_a && v_b;
  assign insn = v_a ? uop[2*INSN_WIDTH-1 -: INSN_WIDTH] : v_b ? uop[INSN_WIDTH-1:0] : '0;
  assign tag = v_a ? uop[W-1 -: TAG_BITS] : v_b ? uop[W-TAG_BITS-1 -: TAG_BITS] : '0;
  assign pop = !offer || (issue && !(v_a && v_b));
endmodule

// File: rtl/uop_issue_queue.sv
// uop_issue_queue: buffers two-slot uop words and issues one instruction per cycle with tag-based flush
module uop_issue_queue import uop_pkg::*; #(
  parameter int DEPTH = UOP_BUF_SIZE,
  parameter int TAG_BITS = MAX_PREDICT_DEPTH_BITS,
  parameter int INSN_WIDTH = uop_pkg::INSN_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [2*TAG_BITS+2*INSN_WIDTH-1:0] in_uop,
  output logic out_valid,
  input  logic out_ready,
  output logic [INSN_WIDTH-1:0] out_insn,
  output logic [TAG_BITS-1:0] out_tag,
  output logic out_slot,
  input  logic flush_valid,
  input  logic [TAG_BITS-1:0] flush_tag,
  output logic [$clog2(DEPTH):0] count
);
  localparam int W = 2*TAG_BITS + 2*INSN_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] va, vb;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic nonempty, push, issue, offer, sel_pop, pop, head_va, head_vb, in_va, in_vb;
  assign nonempty = count != '0;
  assign head_va = nonempty && va[rd_ptr];
  assign head_vb = nonempty && vb[rd_ptr];
  assign in_ready = count != CW'(DEPTH);
  assign push = in_valid && in_ready;
  assign out_valid = offer && !(flush_valid && flush_tag == out_tag);
  assign issue = out_valid && out_ready;
  assign pop = nonempty && sel_pop;
  assign in_va = in_uop[2*INSN_WIDTH-1 -: INSN_WIDTH] != '0 && !(flush_valid && in_uop[W-1 -: TAG_BITS] == flush_tag);
  assign in_vb = in_uop[INSN_WIDTH-1:0] != '0 && !(flush_valid && in_uop[W-TAG_BITS-1 -: TAG_BITS] == flush_tag);
  uop_slot_select #(.TAG_BITS(TAG_BITS), .INSN_WIDTH(INSN_WIDTH)) u_sel (
    .v_a(head_va),
    .v_b(head_vb),
    .uop(mem[rd_ptr]),
    .issue(issue),
    .offer(offer),
    .insn(out_insn),
    .tag(out_tag),
    .slot(out_slot),
    .pop(sel_pop)
  );
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_uop;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      va <= '0;
      vb <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_valid && mem[i][W-1 -: TAG_BITS] == flush_tag) va[i] <= 1'b0;
        if (flush_valid && mem[i][W-TAG_BITS-1 -: TAG_BITS] == flush_tag) vb[i] <= 1'b0;
      end
      if (issue && !out_slot) va[rd_ptr] <= 1'b0;
      if (issue && out_slot) vb[rd_ptr] <= 1'b0;
      if (push) begin
        va[wr_ptr] <= in_va;
        vb[wr_ptr] <= in_vb;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_uop_issue_queue.sv
// tb_uop_issue_queue: directed self-checking bench for the uop issue queue
module tb_uop_issue_queue;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, out_slot, flush_valid;
  logic [67:0] in_uop;
  logic [31:0] out_insn;
  logic [1:0] out_tag, flush_tag;
  logic [3:0] count;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] e4 [5] = '{32'h200, 32'h202, 32'h204, 32'h206, 32'h301};
  always #5 clk = ~clk;
  uop_issue_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_tag(out_tag),
    .out_slot(out_slot), .flush_valid(flush_valid), .flush_tag(flush_tag), .count(count)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask
  initial begin
    reset = 1; in_valid = 0; in_uop = '0; out_ready = 0; flush_valid = 0; flush_tag = 0;
    tick;
    tick;
    reset = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_insn", out_insn, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_slot", out_slot, 0);
    in_valid = 1; in_uop = {2'd2, 2'd2, 32'h25270004, 32'h25270005}; out_ready = 1;
    #1;
    chk("t1_no_bypass", out_valid, 0);
    tick;
    in_valid = 0;
    #1;
    chk("t1_valid_a", out_valid, 1);
    chk("t1_insn_a", out_insn, 32'h25270004);
    chk("t1_tag_a", out_tag, 2);
    chk("t1_slot_a", out_slot, 0);
    chk("t1_count", count, 1);
    tick;
    chk("t1_valid_b", out_valid, 1);
    chk("t1_insn_b", out_insn, 32'h25270005);
    chk("t1_slot_b", out_slot, 1);
    tick;
    chk("t1_empty_count", count, 0);
    chk("t1_empty_valid", out_valid, 0);
    in_valid = 1; in_uop = {2'd1, 2'd3, 32'h0, 32'h0000ABCD};
    tick;
    in_valid = 0;
    #1;
    chk("t2_valid", out_valid, 1);
    chk("t2_insn", out_insn, 32'h0000ABCD);
    chk("t2_slot", out_slot, 1);
    chk("t2_tag", out_tag, 3);
    tick;
    chk("t2_count", count, 0);
    in_valid = 1; in_uop = '0;
    tick;
    in_valid = 0;
    #1;
    chk("t2_zero_count", count, 1);
    chk("t2_zero_valid", out_valid, 0);
    tick;
    chk("t2_zero_popped", count, 0);
    chk("t2_zero_valid2", out_valid, 0);
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      in_uop = {2'd0, 2'd1, 32'(32'h100 + 2*k), 32'(32'h101 + 2*k)};
      tick;
    end
    in_uop = {2'd0, 2'd0, 32'hDEAD, 32'hBEEF};
    #1;
    chk("t3_full_count", count, 8);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_head", out_insn, 32'h100);
    tick;
    in_valid = 0;
    #1;
    chk("t3_refused", count, 8);
    chk("t3_hold_insn", out_insn, 32'h100);
    chk("t3_hold_valid", out_valid, 1);
    out_ready = 1;
    #1;
    for (int j = 0; j < 16; j++) begin
      chk("t3_order_insn", out_insn, 32'(32'h100 + j));
      chk("t3_order_slot", out_slot, 32'(j % 2));
      chk("t3_order_tag", out_tag, 32'(j % 2));
      tick;
    end
    chk("t3_drained", count, 0);
    chk("t3_drained_valid", out_valid, 0);
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      in_uop = {2'd1, 2'd2, 32'(32'h200 + 2*k), 32'(32'h201 + 2*k)};
      tick;
    end
    in_uop = {2'd2, 2'd1, 32'h300, 32'h301};
    flush_valid = 1; flush_tag = 2;
    #1;
    chk("t4_flush_head_ok", out_valid, 1);
    chk("t4_flush_head_insn", out_insn, 32'h200);
    tick;
    in_valid = 0; flush_valid = 0; out_ready = 1;
    #1;
    chk("t4_count", count, 5);
    for (int j = 0; j < 5; j++) begin
      chk("t4_valid", out_valid, 1);
      chk("t4_insn", out_insn, e4[j]);
      chk("t4_tag", out_tag, 1);
      tick;
    end
    chk("t4_drained", count, 0);
    chk("t4_drained_valid", out_valid, 0);
    out_ready = 0; in_valid = 1; in_uop = {2'd3, 2'd0, 32'h333, 32'h0};
    tick;
    in_valid = 0;
    #1;
    chk("t5_offer", out_valid, 1);
    out_ready = 1; flush_valid = 1; flush_tag = 3;
    #1;
    chk("t5_flush_kill", out_valid, 0);
    tick;
    flush_valid = 0;
    #1;
    chk("t5_after_valid", out_valid, 0);
    chk("t5_after_count", count, 1);
    tick;
    chk("t5_popped", count, 0);
    chk("t5_never_issued", out_valid, 0);
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      in_uop = {2'd0, 2'd0, 32'(32'h400 + k), 32'h0};
      tick;
    end
    chk("t6_pre_count", count, 5);
    chk("t6_pre_valid", out_valid, 1);
    reset = 1;
    tick;
    reset = 0; in_valid = 0;
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 1);
    in_valid = 1; in_uop = {2'd1, 2'd1, 32'h500, 32'h0}; out_ready = 1;
    tick;
    in_valid = 0;
    #1;
    chk("t6_post_valid", out_valid, 1);
    chk("t6_post_insn", out_insn, 32'h500);
    tick;
    chk("t6_post_count", count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uop_issue_queue.md
Name: uop_issue_queue

Overview:
- Sits directly downstream of microcode_unit and consumes its uop words.
- Each uop word is {tag_a, tag_b, insn_a, insn_b}: two 32-bit instructions, each with its own branch tag. Slot a is the older instruction.
- The block buffers uop words in a FIFO and issues one instruction per cycle, oldest first, over a valid/ready handshake.
- It drops empty slots and selectively kills instructions by branch tag when a branch misprediction flush arrives.

Parameters:
- DEPTH, 8, number of buffered uop words; must be a power of 2, at least 2.
- TAG_BITS, MAX_PREDICT_DEPTH_BITS (2), width of one branch tag.
- INSN_WIDTH, 32, width of one instruction.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream uop word is valid.
- in_ready  out  1  queue can accept a word this cycle.
- in_uop  in  2*TAG_BITS+2*INSN_WIDTH  {tag_a, tag_b, insn_a, insn_b}, MSB first.
- out_valid  out  1  an instruction is offered.
- out_ready  in  1  downstream accepts it.
- out_insn  out  INSN_WIDTH  offered instruction.
- out_tag  out  TAG_BITS  branch tag of the offered instruction.
- out_slot  out  1  0 means slot a, 1 means slot b.
- flush_valid  in  1  misprediction kill request.
- flush_tag  in  TAG_BITS  tag to kill.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset: wr_ptr = rd_ptr = count = 0 and all slot-valid bits = 0. This gives out_valid 0, in_ready 1, out_insn 0, out_tag 0, out_slot 0. Reset mid-operation discards all contents on the next edge; handshakes in the reset cycle are ignored.
- Storage: each entry holds the uop word plus two slot-valid bits v_a and v_b.
- Push happens when in_valid && in_ready.
  - v_a is set to (insn_a != 0) and v_b to (insn_b != 0), so all-zero instructions are bubbles and are never issued.
  - A word whose slots are both zero is still stored, occupies an entry, and is popped later with no output.
- in_ready = (count != DEPTH). It depends on registered state only; there is no combinational path from out_ready to in_ready.
- Latency: a word pushed in cycle N can be offered at the earliest in cycle N+1. There is no bypass.
- Head selection is combinational from the head entry:
  - If v_a is set, offer insn_a with tag_a and out_slot 0.
  - Otherwise, if v_b is set, offer insn_b with tag_b and out_slot 1.
  - Output fields are 0 when nothing is offered.
- out_valid = !empty && (v_a || v_b) && !(flush_valid && flush_tag == out_tag). Flush takes priority, so a matching instruction is never issued in the flush cycle.
- Issue (out_valid && out_ready) clears the issued slot's valid bit. If the head then has no valid slot, it is popped in the same cycle.
- A head with v_a = v_b = 0 and count > 0 pops in one cycle without asserting out_valid.
- Holding rule: while out_valid && !out_ready, out_insn, out_tag and out_slot stay stable unless a flush kills the offered instruction.
- Flush: in the flush cycle, every stored slot whose tag equals flush_tag has its valid bit cleared at the edge. This includes the head and a partially issued entry.
  - A word being pushed in the same cycle is filtered too: a slot matching flush_tag is stored with its valid bit 0.
  - Emptied entries are removed by the normal head pop, one per cycle; no compaction.
- Simultaneous push and pop: both occur and count is unchanged. At full, push is refused even if a pop happens in the same cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. count distinguishes full from empty.

Decomposition:
- Shared package uop_pkg:
  - UOP_BUF_WIDTH, UOP_BUF_SIZE, MAX_PREDICT_DEPTH_BITS and INSN_WIDTH.
  - Typedef uop_word_t, a packed struct of tag_a, tag_b, insn_a, insn_b that matches the microcode_unit layout.
  - Typedef branch_tag_t.
- One sub-module, uop_slot_select: combinational head-slot picker taking v_a, v_b and the uop word and producing the offered fields and the pop decision. Reused for a future second issue port.

Test Plan:
- Push {2,2,0x25270004,0x25270005} with out_ready = 1 -> cycle+1: out_insn 0x25270004, tag 2, slot 0; cycle+2: 0x25270005, slot 1; then count 0 and out_valid 0.
- Push {1,3,0,0x0000ABCD} -> only 0x0000ABCD is issued, with out_slot 1. Push an all-zero word -> popped within one cycle, out_valid never asserted, count returns to 0.
- out_ready = 0; push 8 distinct words -> count 8, in_ready 0, and a 9th in_valid is not accepted. Raise out_ready -> 16 instructions issue in FIFO order; pointers wrap on the following fill.
- Fill with tags alternating 1 and 2, hold out_ready = 0, pulse flush_tag = 2 -> only tag-1 instructions issue, in order; flush in the same cycle as a push of tag 2 drops that word's matching slots.
- Head offering tag 3 with out_ready = 1 and flush_tag = 3 in that cycle -> out_valid 0 that cycle; the instruction is never issued.
- Assert reset while count = 5 and out_valid = 1 -> next cycle count 0, out_valid 0, in_ready 1; a push right after reset issues normally.
